// File: rtl/pilot_pkg.sv
// Shared types and constants for the maze pilot: FSM states, move directions,
// the fixed route and the default gap/timeout lengths.
package pilot_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RST_GAME = 3'd1,
        ST_MOVE     = 3'd2,
        ST_GAP      = 3'd3,
        ST_WAIT_SW  = 3'd4,
        ST_WAIT_END = 3'd5,
        ST_DONE     = 3'd6,
        ST_FAIL     = 3'd7
    } state_e;

    typedef enum logic [1:0] {
        DIR_N = 2'd0,
        DIR_S = 2'd1,
        DIR_E = 2'd2,
        DIR_W = 2'd3
    } dir_e;

    localparam int DEFAULT_GAP_CYCLES = 2;
    localparam int DEFAULT_TIMEOUT    = 8;

    // The sword is awaited after route entry 2; entry 4 is the last move.
    localparam logic [2:0] SWORD_IDX = 3'd2;
    localparam logic [2:0] LAST_IDX  = 3'd4;

    function automatic dir_e route_dir(input logic [2:0] idx);
        dir_e dir;
        case (idx)
            3'd0:    dir = DIR_E;
            3'd1:    dir = DIR_S;
            3'd2:    dir = DIR_W;
            3'd3:    dir = DIR_E;
            3'd4:    dir = DIR_E;
            default: dir = DIR_E;
        endcase
        return dir;
    endfunction

    // One-hot pulse pattern ordered {n, s, e, w}.
    function automatic logic [3:0] dir_onehot(input dir_e dir);
        logic [3:0] oh;
        case (dir)
            DIR_N:   oh = 4'b1000;
            DIR_S:   oh = 4'b0100;
            DIR_E:   oh = 4'b0010;
            DIR_W:   oh = 4'b0001;
            default: oh = 4'b0000;
        endcase
        return oh;
    endfunction

    function automatic logic [2:0] sat_inc(input logic [2:0] val);
        return (val == 3'd7) ? 3'd7 : val + 3'd1;
    endfunction

endpackage

// File: rtl/pilot_timer.sv
// Loadable down-counter shared by the inter-move gap and the feedback timeouts.
// expire is high while the count has reached its final cycle.
module pilot_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             count,
    output logic             expire
);

    logic [WIDTH-1:0] cnt;

    // Load has priority over counting; the count stops at zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= {WIDTH{1'b0}};
        end else if (load) begin
            cnt <= load_val;
        end else if (count && (cnt != {WIDTH{1'b0}})) begin
            cnt <= cnt - WIDTH'(1);
        end else begin
            cnt <= cnt;
        end
    end

    assign expire = (cnt <= WIDTH'(1));

endmodule

// File: rtl/maze_pilot.sv
// Drives the room game along the fixed route E,S,W,(sword),E,E and reports the outcome.
// Define PILOT_RETRY_EN to allow one automatic rerun after the first failure.
module maze_pilot
    import pilot_pkg::*;
#(
    parameter int GAP_CYCLES = DEFAULT_GAP_CYCLES,
    parameter int TIMEOUT    = DEFAULT_TIMEOUT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       sw,
    input  logic       win,
    input  logic       d,
    output logic       n,
    output logic       s,
    output logic       e,
    output logic       w,
    output logic       v,
    output logic       game_rst,
    output logic       busy,
    output logic       done,
    output logic       fail,
    output logic [2:0] move_cnt
);

    localparam logic [3:0] GAP_VAL     = 4'(GAP_CYCLES);
    localparam logic [3:0] TIMEOUT_VAL = 4'(TIMEOUT);

    state_e     state;
    logic [2:0] idx;
    logic       tmr_load;
    logic [3:0] tmr_val;
    logic       tmr_count;
    logic       tmr_expire;
    logic       failure;
`ifdef PILOT_RETRY_EN
    logic       retry_used;
`endif

    pilot_timer #(.WIDTH(4)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .count    (tmr_count),
        .expire   (tmr_expire)
    );

    // Timer control and failure detection; feedback is only looked at in the wait states.
    always_comb begin
        tmr_load  = 1'b0;
        tmr_val   = 4'd0;
        tmr_count = 1'b0;
        failure   = 1'b0;
        case (state)
            ST_MOVE: begin
                tmr_load = 1'b1;
                if ((idx == SWORD_IDX) || (idx == LAST_IDX)) begin
                    tmr_val = TIMEOUT_VAL;
                end else begin
                    tmr_val = GAP_VAL;
                end
            end
            ST_GAP: begin
                tmr_count = 1'b1;
            end
            ST_WAIT_SW: begin
                if (sw) begin
                    tmr_load = 1'b1;
                    tmr_val  = GAP_VAL;
                end else begin
                    tmr_count = 1'b1;
                    failure   = tmr_expire;
                end
            end
            ST_WAIT_END: begin
                tmr_count = 1'b1;
                failure   = d | (~win & tmr_expire);
            end
            default: begin
                tmr_count = 1'b0;
            end
        endcase
    end

    // Main sequencer with all outputs registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            idx        <= 3'd0;
            {n, s, e, w} <= 4'b0000;
            v          <= 1'b0;
            game_rst   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            fail       <= 1'b0;
            move_cnt   <= 3'd0;
`ifdef PILOT_RETRY_EN
            retry_used <= 1'b0;
`endif
        end else begin
            game_rst     <= 1'b0;
            {n, s, e, w} <= 4'b0000;
            case (state)
                ST_IDLE, ST_DONE, ST_FAIL: begin
                    if (start) begin
                        state    <= ST_RST_GAME;
                        game_rst <= 1'b1;
                        idx      <= 3'd0;
                        v        <= 1'b0;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        fail     <= 1'b0;
                        move_cnt <= 3'd0;
`ifdef PILOT_RETRY_EN
                        retry_used <= 1'b0;
`endif
                    end
                end
                ST_RST_GAME: begin
                    state        <= ST_MOVE;
                    {n, s, e, w} <= dir_onehot(route_dir(idx));
                end
                ST_MOVE: begin
                    move_cnt <= sat_inc(move_cnt);
                    idx      <= idx + 3'd1;
                    if (idx == SWORD_IDX) begin
                        state <= ST_WAIT_SW;
                    end else if (idx == LAST_IDX) begin
                        state <= ST_WAIT_END;
                    end else begin
                        state <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (tmr_expire) begin
                        state        <= ST_MOVE;
                        {n, s, e, w} <= dir_onehot(route_dir(idx));
                    end
                end
                ST_WAIT_SW: begin
                    if (sw) begin
                        v     <= 1'b1;
                        state <= ST_GAP;
                    end
                end
                ST_WAIT_END: begin
                    if (win && !d) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase

            // A failure overrides whatever the wait state decided above.
            if (failure) begin
`ifdef PILOT_RETRY_EN
                if (!retry_used) begin
                    retry_used <= 1'b1;
                    state      <= ST_RST_GAME;
                    game_rst   <= 1'b1;
                    idx        <= 3'd0;
                    v          <= 1'b0;
                    move_cnt   <= 3'd0;
                end else begin
                    state <= ST_FAIL;
                    fail  <= 1'b1;
                    busy  <= 1'b0;
                end
`else
                state <= ST_FAIL;
                fail  <= 1'b1;
                busy  <= 1'b0;
`endif
            end
        end
    end

endmodule

// File: tb/tb_maze_pilot.sv
// Self-checking bench for maze_pilot: a timeline model of each run predicts every
// output cycle by cycle while feedback inputs are randomized outside their trigger points.
`timescale 1ns/1ps
module tb_maze_pilot;

    localparam int GAP = 2;
    localparam int TO  = 8;

    logic       clk = 1'b0;
    logic       reset, start, sw, win, d;
    logic       n, s, e, w, v, game_rst, busy, done, fail;
    logic [2:0] move_cnt;

    int checks = 0;
    int errors = 0;

    maze_pilot #(.GAP_CYCLES(GAP), .TIMEOUT(TO)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .sw       (sw),
        .win      (win),
        .d        (d),
        .n        (n),
        .s        (s),
        .e        (e),
        .w        (w),
        .v        (v),
        .game_rst (game_rst),
        .busy     (busy),
        .done     (done),
        .fail     (fail),
        .move_cnt (move_cnt)
    );

    always #5 clk = ~clk;

    // One expected cycle: inputs to drive plus outputs to expect.
    typedef struct packed {
        logic       start;
        logic       sw;
        logic       win;
        logic       d;
        logic       gr;
        logic [3:0] dir;
        logic       v;
        logic       busy;
        logic       done;
        logic       fail;
        logic [2:0] mc;
    } cyc_t;

    cyc_t       tl[$];
    cyc_t       cur;
    cyc_t       tmp;
    int         gap4_idx;
    bit         start_noise;
    logic [3:0] route_oh [5];

    function automatic logic [12:0] observed();
        return {game_rst, n, s, e, w, v, busy, done, fail, move_cnt};
    endfunction

    function automatic logic [12:0] expv(input cyc_t c);
        return {c.gr, c.dir, c.v, c.busy, c.done, c.fail, c.mc};
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic check(input string tag, input logic [12:0] obs, input logic [12:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed={gr,nsew,v,busy,done,fail,cnt}=%b expected=%b", tag, obs, exp_v);
        end
    endtask

    task automatic push(input logic sw_i, input logic win_i, input logic d_i);
        cyc_t c;
        c       = cur;
        c.sw    = sw_i;
        c.win   = win_i;
        c.d     = d_i;
        c.start = start_noise && cur.busy && ($urandom_range(0, 3) == 0);
        tl.push_back(c);
    endtask

    // Builds the expected timeline of one run; k* = wait cycle of the trigger
    // (>= TO means never), typ: 0 win, 1 d, 2 win+d. Index 0/1 = first/retry attempt.
    task automatic build_run(input int ksw0, input int ksw1, input int kend0, input int kend1,
                             input int typ0, input int typ1);
        int   ksw [2];
        int   kend[2];
        int   typ [2];
        int   attempts;
        bit   ok, won, got;
        cyc_t c;
        ksw[0] = ksw0;   ksw[1] = ksw1;
        kend[0] = kend0; kend[1] = kend1;
        typ[0] = typ0;   typ[1] = typ1;
        tl.delete();
        gap4_idx = -1;
        c = cur; c.start = 1'b1; c.sw = rb(); c.win = rb(); c.d = rb();
        tl.push_back(c);
`ifdef PILOT_RETRY_EN
        attempts = 2;
`else
        attempts = 1;
`endif
        won = 1'b0;
        for (int a = 0; a < attempts; a++) begin
            cur.gr = 1'b1; cur.dir = 4'b0000; cur.v = 1'b0; cur.busy = 1'b1;
            cur.done = 1'b0; cur.fail = 1'b0; cur.mc = 3'd0;
            push(rb(), rb(), rb());
            cur.gr = 1'b0;
            ok = 1'b1;
            won = 1'b0;
            for (int m = 0; m < 5 && ok; m++) begin
                cur.dir = route_oh[m];
                push(rb(), rb(), rb());
                cur.dir = 4'b0000;
                if (cur.mc != 3'd7) cur.mc = cur.mc + 3'd1;
                if (m == 2) begin
                    got = 1'b0;
                    for (int j = 0; j < TO && !got; j++) begin
                        if (j == ksw[a]) begin
                            push(1'b1, rb(), rb());
                            got = 1'b1;
                        end else begin
                            push(1'b0, rb(), rb());
                        end
                    end
                    if (got) begin
                        cur.v = 1'b1;
                        for (int g = 0; g < GAP; g++) push(rb(), rb(), rb());
                    end else begin
                        ok = 1'b0;
                    end
                end else if (m == 4) begin
                    got = 1'b0;
                    for (int j = 0; j < TO && !got; j++) begin
                        if (j == kend[a]) begin
                            push(rb(), 1'(typ[a] != 1), 1'(typ[a] != 0));
                            got = 1'b1;
                            won = (typ[a] == 0);
                        end else begin
                            push(rb(), 1'b0, 1'b0);
                        end
                    end
                    if (!won) ok = 1'b0;
                end else begin
                    if (m == 3) gap4_idx = tl.size();
                    for (int g = 0; g < GAP; g++) push(rb(), rb(), rb());
                end
            end
            if (won) break;
        end
        cur.busy = 1'b0;
        if (won) cur.done = 1'b1;
        else     cur.fail = 1'b1;
        for (int k = 0; k < 3; k++) push(rb(), rb(), rb());
    endtask

    // Replays the timeline: check outputs mid-cycle, then drive that cycle's inputs.
    task automatic play(input int stop_at);
        for (int i = 0; i < tl.size(); i++) begin
            @(negedge clk);
            check($sformatf("cycle%0d", i), observed(), expv(tl[i]));
            start = tl[i].start;
            sw    = tl[i].sw;
            win   = tl[i].win;
            d     = tl[i].d;
            if (i == stop_at) break;
        end
    endtask

    initial begin
        route_oh    = '{4'b0010, 4'b0100, 4'b0001, 4'b0010, 4'b0010};
        reset       = 1'b1;
        start       = 1'b0;
        sw          = 1'b0;
        win         = 1'b0;
        d           = 1'b0;
        cur         = '0;
        start_noise = 1'b0;

        repeat (2) @(negedge clk);
        check("reset_state", observed(), 13'b0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_after_reset", observed(), 13'b0);

        // Happy path: sword and win on the first wait cycle.
        build_run(0, 0, 0, 0, 0, 0);
        play(-1);

        // Sword never arrives.
        build_run(TO, TO, 0, 0, 0, 0);
        play(-1);

        // win and d together.
        build_run(0, 0, 0, 0, 2, 2);
        play(-1);

        // start pulsed during the second move, plus random start noise while busy.
        start_noise = 1'b1;
        build_run(1, 0, 3, 0, 0, 0);
        tmp = tl[5];
        tmp.start = 1'b1;
        tl[5] = tmp;
        play(-1);

        // d on the first attempt, win on the retry (plain fail without retry).
        build_run(0, 0, 0, 2, 1, 0);
        play(-1);

        // Reset in the gap after move 4, then a full run from scratch.
        build_run(0, 0, 0, 0, 0, 0);
        play(gap4_idx);
        #1;
        reset = 1'b1;
        #1;
        check("reset_async_midgap", observed(), 13'b0);
        @(negedge clk);
        check("reset_held", observed(), 13'b0);
        start = 1'b0; sw = 1'b0; win = 1'b0; d = 1'b0;
        reset = 1'b0;
        cur   = '0;
        build_run(2, 0, 1, 0, 0, 0);
        play(-1);

        // Random runs.
        for (int r = 0; r < 14; r++) begin
            build_run($urandom_range(0, TO), $urandom_range(0, TO),
                      $urandom_range(0, TO), $urandom_range(0, TO),
                      $urandom_range(0, 2), $urandom_range(0, 2));
            play(-1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
